dm_port_arbiter: RTL
====================

# dm_port_arbiter

Arbiter and sequencer that shares the single data-memory (DM) port between the CPU MEM stage and a word-burst DMA requester. Sits directly in front of DM, drives its write enable, address, write data, length and PC inputs, and returns registered read data to the winner. The DMA side requests bursts of consecutive words. The CPU side issues single byte, halfword or word accesses and is stalled while it loses arbitration.

## Interface
Parameters:
- BURST_MAX, 8: maximum beats per DMA burst; d_beats above this is clamped to BURST_MAX.
- CNT_W, 4: width of d_beats and the beat counter; must satisfy 2^CNT_W > BURST_MAX.

Ports:
- Clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- c_req  in  1  CPU access request, held until c_ack.
- c_we  in  1  CPU write (1) / read (0).
- c_addr  in  32  CPU byte address.
- c_wdata  in  32  CPU store data.
- c_len  in  2  DM_Word32 / DM_HalfWord16 / DM_Byte8.
- c_pc  in  32  PC of the issuing instruction, forwarded to DM for the store trace.
- c_ack  out  1  CPU access issued this cycle (combinational).
- c_stall  out  1  c_req & ~c_ack.
- c_rvalid  out  1  registered; CPU read data valid.
- c_rdata  out  32  registered CPU read data.
- d_req  in  1  DMA burst request, held until the first d_ack.
- d_we  in  1  burst direction, sampled at first beat.
- d_addr  in  32  burst start address; bits [1:0] forced to 0.
- d_beats  in  CNT_W  beat count; 0 is treated as 1.
- d_wdata  in  32  current beat write data; the DMA advances it on d_ack.
- d_ack  out  1  DMA beat issued this cycle (combinational).
- d_rvalid  out  1  registered; DMA read beat valid.
- d_rdata  out  32  registered DMA read data.
- d_done  out  1  registered one-cycle pulse after the last beat issues.
- m_we  out  1  to DM MemWrite.
- m_addr  out  32  to DM A.
- m_wdata  out  32  to DM WD.
- m_len  out  2  to DM Len.
- m_pc  out  32  to DM PC; 0 for DMA beats.
- m_rdata  in  32  from DM RD (combinational read).

## Operation
- FSM states:
  - IDLE: no burst in progress.
  - BURST: beats remain; latched burst_addr, burst_we and beats_left are held.
- Issue cycle: exactly one of c_ack or d_ack is high, or neither. The m_* outputs mux from the winner; m_we = 0 when neither is granted.
- IDLE:
  - c_req only: grant the CPU.
  - d_req only: grant DMA beat 0 at d_addr.
  - If beats > 1: latch burst_addr = d_addr+4, beats_left = beats-1, and go to BURST.
  - If beats is 0 or 1: pulse d_done next cycle and stay in IDLE.
- BURST:
  - Each DMA-granted cycle issues one word at burst_addr, then burst_addr += 4 and beats_left -= 1.
  - When beats_left reaches 0, pulse d_done next cycle and return to IDLE.
  - d_req is ignored while in BURST.
- Contention (both requesting in the same cycle, in IDLE or BURST): resolved per Configuration.
- DMA beats are always m_len = DM_Word32. Address arithmetic wraps modulo 2^32.
- Read return:
  - c_rdata / d_rdata capture m_rdata on the issue cycle; the matching rvalid is high the next cycle.
  - Write beats produce no rvalid.
- Reset:
  - All outputs are 0 and the state is IDLE.
  - A burst in progress is aborted with no d_done.
  - Pending rvalid is cleared.

## Timing
- Issue: c_ack and d_ack are combinational from the requests and the current state; the DM write commits on the same edge.
- Read latency: 1 cycle from ack to rvalid.
- DMA throughput: 1 beat per cycle when uncontended.
- d_done: asserted on the cycle after the last beat's ack, coincident with the last read's d_rvalid.
- Single-beat burst: d_ack and d_done are separated by one cycle, and the FSM never enters BURST.

## Configuration
- DM_ARB_FAIR_EN undefined: fixed CPU priority.
  - The CPU preempts between any two DMA beats.
  - The DMA starves while c_req is continuously high; the burst resumes with its counters intact.
- DM_ARB_FAIR_EN defined: round-robin on contention.
  - A last_grant flop decides; on contention the loser of the previous contended cycle wins, so grants alternate beat by beat.
  - last_grant resets to DMA, so the CPU wins the first contended cycle.

## Structure
- Shared package dm_arb_pkg holds the DM_Word32 / DM_HalfWord16 / DM_Byte8 encodings (shared with DM) and the FSM state encoding.
- Sub-module dm_burst_cnt contains burst_addr, beats_left and burst_we, with load, step and clear inputs and a last output. The arbiter FSM and muxes stay in the top level.

## Test plan
- Uncontended CPU store: c_we=1, c_addr=0x10, c_len=Byte8, c_wdata=0xAB.
  - Expect c_ack the same cycle, m_we=1, m_addr=0x10, m_len=Byte8, c_stall=0.
- DMA write burst: d_addr=0x100, d_beats=4, nothing else requesting.
  - Expect d_ack on 4 consecutive cycles with m_addr = 0x100, 0x104, 0x108, 0x10C.
  - Expect d_done one cycle after the 4th ack.
- Contention, macro off: 4-beat DMA read burst, with c_req raised for 2 cycles starting at beat 1.
  - Expect beat 1 to wait: c_ack twice, c_stall=0.
  - Then beats 1–3 at 0x104..0x10C, each d_rvalid one cycle after its ack.
- Contention, macro on: both requesting continuously.
  - Expect c_ack and d_ack to alternate every cycle, CPU first, with c_stall high on DMA cycles.
- Reset at beat 2 of a 6-beat burst.
  - Expect all outputs 0 the next cycle and no d_done.
  - A following d_req with d_beats=1 at 0x200 gives one ack, then d_done.
- d_beats=0 and d_beats=15 with BURST_MAX=8.
  - Expect 1 beat and 8 beats respectively; 32-bit address wrap from 0xFFFFFFFC to 0x0 is correct.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory port: access length codes (also used by DM)
// and the arbiter FSM / grant-history state types.
package dm_arb_pkg;

  localparam logic [1:0] DM_Word32     = 2'd0;
  localparam logic [1:0] DM_HalfWord16 = 2'd1;
  localparam logic [1:0] DM_Byte8      = 2'd2;

  localparam logic [31:0] WORD_STEP = 32'd4;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  typedef enum logic {
    GRANT_CPU,
    GRANT_DMA
  } grant_e;

endpackage

// File: rtl/dm_burst_cnt.sv
// Burst sequencing registers: next beat address, remaining beat count and latched
// direction. Loaded after beat 0 issues, stepped on every later DMA beat.
module dm_burst_cnt
  import dm_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [31:0]      load_addr,
  input  logic [CNT_W-1:0] load_beats,
  input  logic             load_we,
  output logic [31:0]      burst_addr,
  output logic             burst_we,
  output logic             last
);

  logic [CNT_W-1:0] beats_left;

  // load_addr/load_beats describe beat 0, which issues in the load cycle itself
  always_ff @(posedge Clk) begin
    if (clear) begin
      burst_addr <= '0;
      burst_we   <= 1'b0;
      beats_left <= '0;
    end else if (load) begin
      burst_addr <= load_addr + WORD_STEP;
      burst_we   <= load_we;
      beats_left <= load_beats - CNT_W'(1);
    end else if (step) begin
      burst_addr <= burst_addr + WORD_STEP;
      beats_left <= beats_left - CNT_W'(1);
    end
  end

  assign last = (beats_left == CNT_W'(1));

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single DM port between CPU MEM-stage accesses and word-burst DMA.
// Define DM_ARB_FAIR_EN for round-robin on contention; default is fixed CPU priority.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [31:0]      c_addr,
  input  logic [31:0]      c_wdata,
  input  logic [1:0]       c_len,
  input  logic [31:0]      c_pc,
  output logic             c_ack,
  output logic             c_stall,
  output logic             c_rvalid,
  output logic [31:0]      c_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [CNT_W-1:0] d_beats,
  input  logic [31:0]      d_wdata,
  output logic             d_ack,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_done,
  output logic             m_we,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  output logic [1:0]       m_len,
  output logic [31:0]      m_pc,
  input  logic [31:0]      m_rdata
);

  localparam logic [CNT_W-1:0] BEATS_CAP = CNT_W'(BURST_MAX);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] eff_beats;
  logic [31:0]      d_base, burst_addr, dma_addr;
  logic             burst_we, dma_we, cnt_last;
  logic             cnt_load, cnt_step, d_last;
  logic             c_want, d_want, c_win, d_win;

  always_comb begin
    if (d_beats == '0)           eff_beats = CNT_W'(1);
    else if (d_beats > BEATS_CAP) eff_beats = BEATS_CAP;
    else                          eff_beats = d_beats;
  end

  assign d_base   = d_addr & ~32'h3;
  assign dma_addr = (state == ST_BURST) ? burst_addr : d_base;
  assign dma_we   = (state == ST_BURST) ? burst_we   : d_we;

  // Requests are masked during reset so every output reads 0 while it is held
  assign c_want = ~reset & c_req;
  assign d_want = ~reset & ((state == ST_BURST) | d_req);

`ifdef DM_ARB_FAIR_EN
  grant_e last_grant;

  always_comb begin
    c_win = c_want;
    d_win = d_want;
    if (c_want && d_want) begin
      c_win = (last_grant == GRANT_DMA);
      d_win = (last_grant == GRANT_CPU);
    end
  end

  always_ff @(posedge Clk) begin
    if (reset)
      last_grant <= GRANT_DMA;
    else if (c_want && d_want)
      last_grant <= c_win ? GRANT_CPU : GRANT_DMA;
  end
`else
  assign c_win = c_want;
  assign d_win = d_want & ~c_want;
`endif

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_step  = 1'b0;
    d_last    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (d_win) begin
          if (eff_beats > CNT_W'(1)) begin
            cnt_load  = 1'b1;
            state_nxt = ST_BURST;
          end else begin
            d_last = 1'b1;
          end
        end
      end
      ST_BURST: begin
        if (d_win) begin
          cnt_step = 1'b1;
          if (cnt_last) begin
            d_last    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  dm_burst_cnt #(
    .CNT_W (CNT_W)
  ) u_burst_cnt (
    .Clk        (Clk),
    .clear      (reset),
    .load       (cnt_load),
    .step       (cnt_step),
    .load_addr  (d_base),
    .load_beats (eff_beats),
    .load_we    (d_we),
    .burst_addr (burst_addr),
    .burst_we   (burst_we),
    .last       (cnt_last)
  );

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_len   = DM_Word32;
    m_pc    = '0;
    if (c_win) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
      m_len   = c_len;
      m_pc    = c_pc;
    end else if (d_win) begin
      m_we    = dma_we;
      m_addr  = dma_addr;
      m_wdata = d_wdata;
    end
  end

  assign c_ack   = c_win;
  assign d_ack   = d_win;
  assign c_stall = c_want & ~c_win;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      c_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      c_rvalid <= c_win & ~c_we;
      d_rvalid <= d_win & ~dma_we;
      d_done   <= d_last;
      if (c_win && !c_we) c_rdata <= m_rdata;
      if (d_win && !dma_we) d_rdata <= m_rdata;
    end
  end

endmodule
